// File: rtl/udc_pkg.sv
// Shared constants and the load clamp helper for the up/down counter.
package udc_pkg;

    localparam logic MODE_UP  = 1'b1;
    localparam logic MODE_DN  = 1'b0;
    localparam logic BND_WRAP = 1'b0;
    localparam logic BND_SAT  = 1'b1;

    // Out-of-range load values land on the top of the count range.
    function automatic int unsigned clamp_load(input int unsigned val, input int unsigned mod);
        return (val < mod) ? val : mod - 1;
    endfunction

endpackage

// File: rtl/udc_next_calc.sv
// Next-count and boundary-event computation for one enabled count step.
module udc_next_calc
    import udc_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned MOD    = 2**N,
    parameter int unsigned STEP_W = 4
) (
    input  logic [N-1:0]      count,
    input  logic [STEP_W-1:0] step,
    input  logic              mode,
    input  logic              sat,
    output logic [N-1:0]      next_count,
    output logic              ovf_evt,
    output logic              unf_evt
);

    localparam int unsigned NW = N + 1;
    localparam logic [N:0]  MOD_V = NW'(MOD);
    localparam logic [N:0]  MAX_V = NW'(MOD - 1);

    logic [N:0] cnt_ext;
    logic [N:0] step_ext;
    logic [N:0] sum;

    assign cnt_ext  = {1'b0, count};
    assign step_ext = NW'(step);
    assign sum      = cnt_ext + step_ext;

    // Arithmetic is kept at N+1 bits so MOD == 2**N and carries are exact.
    always_comb begin
        next_count = count;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (mode == MODE_UP) begin
            if (sum <= MAX_V) begin
                next_count = N'(sum);
            end else begin
                ovf_evt    = 1'b1;
                next_count = (sat == BND_SAT) ? N'(MAX_V) : N'(sum - MOD_V);
            end
        end else begin
            if (cnt_ext >= step_ext) begin
                next_count = N'(cnt_ext - step_ext);
            end else begin
                unf_evt    = 1'b1;
                next_count = (sat == BND_SAT) ? '0 : N'(cnt_ext + MOD_V - step_ext);
            end
        end
    end

endmodule

// File: rtl/up_down_counter_mod.sv
// Modulo up/down counter with load, enable, variable step and wrap/saturate.
// Define UDC_STICKY_FLAGS_EN to add flag_clr and sticky ovf/unf outputs.
module up_down_counter_mod
    import udc_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned MOD    = 2**N,
    parameter int unsigned STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [N-1:0]      load_val,
    input  logic              mode,
    input  logic              sat,
    input  logic [STEP_W-1:0] step,
`ifdef UDC_STICKY_FLAGS_EN
    input  logic              flag_clr,
    output logic              ovf_sticky,
    output logic              unf_sticky,
`endif
    output logic [N-1:0]      count,
    output logic              at_max,
    output logic              at_min,
    output logic              ovf,
    output logic              unf
);

    logic [N-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic [N-1:0] calc_count;
    logic         calc_ovf;
    logic         calc_unf;

    udc_next_calc #(
        .N      (N),
        .MOD    (MOD),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .count      (count_q),
        .step       (step),
        .mode       (mode),
        .sat        (sat),
        .next_count (calc_count),
        .ovf_evt    (calc_ovf),
        .unf_evt    (calc_unf)
    );

    // Priority: load > en > hold; flags pulse only on enabled boundary crossings.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (load) begin
            count_d = N'(clamp_load(32'(load_val), MOD));
        end else if (en) begin
            count_d = calc_count;
            ovf_d   = calc_ovf;
            unf_d   = calc_unf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef UDC_STICKY_FLAGS_EN
    logic ovf_sticky_q, ovf_sticky_d;
    logic unf_sticky_q, unf_sticky_d;

    // A new event in the same cycle as flag_clr keeps the flag set.
    always_comb begin
        ovf_sticky_d = ovf_d | (ovf_sticky_q & ~flag_clr);
        unf_sticky_d = unf_d | (unf_sticky_q & ~flag_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;
`endif

    assign count  = count_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign at_max = (count_q == N'(MOD - 1));
    assign at_min = (count_q == '0);

    a_step_legal: assert property (@(posedge clk) disable iff (!rst)
        (en && !load) |-> (32'(step) < MOD));

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Scoreboard bench for up_down_counter_mod with N=8, MOD=10, STEP_W=4.
module tb_up_down_counter_mod;

    localparam int unsigned N      = 8;
    localparam int unsigned MOD    = 10;
    localparam int unsigned STEP_W = 4;

    logic              clk;
    logic              rst;
    logic              en;
    logic              load;
    logic [N-1:0]      load_val;
    logic              mode;
    logic              sat;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      count;
    logic              at_max;
    logic              at_min;
    logic              ovf;
    logic              unf;
`ifdef UDC_STICKY_FLAGS_EN
    logic              flag_clr;
    logic              ovf_sticky;
    logic              unf_sticky;
`endif

    up_down_counter_mod #(
        .N      (N),
        .MOD    (MOD),
        .STEP_W (STEP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
        .mode       (mode),
        .sat        (sat),
        .step       (step),
`ifdef UDC_STICKY_FLAGS_EN
        .flag_clr   (flag_clr),
        .ovf_sticky (ovf_sticky),
        .unf_sticky (unf_sticky),
`endif
        .count      (count),
        .at_max     (at_max),
        .at_min     (at_min),
        .ovf        (ovf),
        .unf        (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] count;
        logic         ovf;
        logic         unf;
        logic         amax;
        logic         amin;
        logic         os;
        logic         us;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    int   m_cnt = 0;
    bit   m_os  = 1'b0;
    bit   m_us  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    // Predict the post-edge state, push it, clock once and compare.
    task automatic run_cycle(input string tag);
        exp_t e;
        exp_t g;
        int   s;
        bit   mo;
        bit   mu;
        bit   clr;
        mo  = 1'b0;
        mu  = 1'b0;
        clr = 1'b0;
`ifdef UDC_STICKY_FLAGS_EN
        clr = flag_clr;
`endif
        if (!rst) begin
            m_cnt = 0;
            m_os  = 1'b0;
            m_us  = 1'b0;
        end else begin
            if (load) begin
                m_cnt = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
            end else if (en) begin
                if (mode) begin
                    s = m_cnt + int'(step);
                    if (s <= MOD - 1) m_cnt = s;
                    else begin
                        mo    = 1'b1;
                        m_cnt = sat ? MOD - 1 : s - MOD;
                    end
                end else begin
                    if (m_cnt >= int'(step)) m_cnt = m_cnt - int'(step);
                    else begin
                        mu    = 1'b1;
                        m_cnt = sat ? 0 : m_cnt + MOD - int'(step);
                    end
                end
            end
            m_os = mo | (m_os & ~clr);
            m_us = mu | (m_us & ~clr);
        end
        e.count = N'(m_cnt);
        e.ovf   = mo;
        e.unf   = mu;
        e.amax  = (m_cnt == MOD - 1);
        e.amin  = (m_cnt == 0);
        e.os    = m_os;
        e.us    = m_us;
        q.push_back(e);

        @(posedge clk);
        #1;
        e = q.pop_front();
        g = '0;
        g.count = count;
        g.ovf   = ovf;
        g.unf   = unf;
        g.amax  = at_max;
        g.amin  = at_min;
        check({tag, ".count"},  32'(g.count), 32'(e.count));
        check({tag, ".ovf"},    32'(g.ovf),   32'(e.ovf));
        check({tag, ".unf"},    32'(g.unf),   32'(e.unf));
        check({tag, ".at_max"}, 32'(g.amax),  32'(e.amax));
        check({tag, ".at_min"}, 32'(g.amin),  32'(e.amin));
`ifdef UDC_STICKY_FLAGS_EN
        check({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(e.os));
        check({tag, ".unf_sticky"}, 32'(unf_sticky), 32'(e.us));
`endif
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic [N-1:0] lv,
                         input logic m, input logic s, input logic [STEP_W-1:0] st);
        rst      = r;
        en       = e;
        load     = l;
        load_val = lv;
        mode     = m;
        sat      = s;
        step     = st;
    endtask

    task automatic load_to(input logic [N-1:0] v);
        drive(1'b1, 1'b0, 1'b1, v, 1'b1, 1'b0, 4'd0);
        run_cycle("load");
    endtask

    initial begin
`ifdef UDC_STICKY_FLAGS_EN
        flag_clr = 1'b0;
`endif
        // Reset dominates a simultaneous load and enable
        drive(1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 4'd1);
        run_cycle("rst_hold0");
        run_cycle("rst_hold1");
        drive(1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 4'd1);
        run_cycle("rst_release_load");

        // Wrap up 8+3 -> 1, then pulse drops
        load_to(8'd8);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 4'd3);
        run_cycle("wrap_up");
        en = 1'b0;
        run_cycle("wrap_up_idle");

        // Wrap down 1-3 -> 8
        load_to(8'd1);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd3);
        run_cycle("wrap_dn");
        en = 1'b0;
        run_cycle("wrap_dn_idle");

        // Saturate up, sit at top, then down by 9 to exactly 0
        load_to(8'd8);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 4'd3);
        run_cycle("sat_up0");
        run_cycle("sat_up1");
        run_cycle("sat_up2");
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 4'd9);
        run_cycle("sat_dn9");
        run_cycle("sat_dn_floor");

        // Load clamp, hold with en=0, zero step
        load_to(8'd200);
        load_to(8'd10);
        en = 1'b0;
        for (int i = 0; i < 5; i++) run_cycle("hold");
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 4'd0);
        run_cycle("step0_up");
        mode = 1'b0;
        run_cycle("step0_dn");
        // Load ignores en/mode/step and never flags
        drive(1'b1, 1'b1, 1'b1, 8'd9, 1'b1, 1'b0, 4'd5);
        run_cycle("load_over_en");

`ifdef UDC_STICKY_FLAGS_EN
        load_to(8'd8);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 4'd3);
        run_cycle("stk_set");
        en = 1'b0;
        for (int i = 0; i < 10; i++) run_cycle("stk_hold");
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 4'd9);
        flag_clr = 1'b1;
        run_cycle("stk_clr_and_set");
        en = 1'b0;
        run_cycle("stk_clr");
        flag_clr = 1'b0;
        load_to(8'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd2);
        run_cycle("stk_unf_set");
        en = 1'b0;
        run_cycle("stk_unf_hold");
`endif

        // Randomised traffic, legal steps only
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, MOD - 1)));
`ifdef UDC_STICKY_FLAGS_EN
            flag_clr = ($urandom_range(0, 5) == 0);
`endif
            run_cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/up_down_counter_mod.md
Name: up_down_counter_mod

Overview:
Parametrised successor to the basic up/down counter. Adds programmable modulus, variable step, synchronous load, count enable, and wrap-or-saturate boundary handling. Flags overflow and underflow events. Used as a general-purpose position, index or timer counter in datapath and control blocks.

Parameters:
N, 8, counter width in bits.
MOD, 2**N, modulus; the count range is 0..MOD-1; legal range is 2 <= MOD <= 2**N.
STEP_W, 4, width of the step input.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
en  input  1  count enable.
load  input  1  synchronous load strobe.
load_val  input  N  value to load.
mode  input  1  direction: 1 = up, 0 = down.
sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
step  input  STEP_W  increment/decrement magnitude; legal values 0..min(2**STEP_W-1, MOD-1).
count  output  N  current count, registered.
at_max  output  1  combinational; count == MOD-1.
at_min  output  1  combinational; count == 0.
ovf  output  1  registered one-cycle pulse on an up-count boundary crossing.
unf  output  1  registered one-cycle pulse on a down-count boundary crossing.

Behaviour:
- Reset: rst low at a clk edge forces count=0, ovf=0, unf=0, and clears any sticky flags. Reset has priority over all other inputs. rst low mid-operation discards any load or count in that cycle.
- Priority on each edge (rst high): load > en > hold.
- Load: count <= load_val if load_val < MOD, else count <= MOD-1. A load never raises ovf or unf. mode, sat, step and en are ignored in that cycle.
- Count (en=1, load=0): the sum/difference is computed at N+1 bits, so no intermediate truncation.
  - Up, sum = count+step:
    - If sum <= MOD-1: count <= sum.
    - Otherwise, wrap: count <= sum-MOD. Saturate: count <= MOD-1.
    - ovf=1 for the next cycle in either boundary mode.
  - Down, diff = count-step:
    - If count >= step: count <= diff.
    - Otherwise, wrap: count <= count+MOD-step. Saturate: count <= 0.
    - unf=1 for the next cycle.
  - Saturate sitting at the boundary (e.g. count=MOD-1, up, step>0) still pulses ovf every enabled cycle. The equivalent down case pulses unf.
- step=0 with en=1: count holds, no flags.
- en=0 and load=0: count holds; ovf and unf are 0.
- ovf and unf are never both 1. Each is 1 for exactly one cycle per event and deasserts the following cycle unless a new event occurs.
- Latency: count, ovf and unf update one cycle after the inputs are sampled. at_max and at_min follow count combinationally.
- Illegal step values (>= MOD): behaviour is undefined. An assertion flags them in simulation.

Optional Feature:
Macro UDC_STICKY_FLAGS_EN.
- Defined: adds input flag_clr (1 bit) and outputs ovf_sticky and unf_sticky (1 bit each).
  - Each sticky flag sets on its pulse condition and holds until flag_clr=1 or reset.
  - If a set and flag_clr occur in the same cycle, set wins.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package udc_pkg holds:
  - localparams MODE_UP=1'b1, MODE_DN=1'b0, BND_WRAP=1'b0, BND_SAT=1'b1.
  - A function clamp_load(val, mod).
- One combinational sub-module, udc_next_calc:
  - Inputs: count, step, mode, sat.
  - Outputs: next_count, ovf_evt, unf_evt.
  - The top module holds the registers, priority logic and the optional sticky flags.

Test Plan:
- Reset/priority: N=8, MOD=10. Hold rst low with load=1, load_val=5, en=1 → count=0, ovf=unf=0. Release rst → load takes effect next edge, count=5.
- Wrap up: MOD=10, count=8, step=3, mode=1, sat=0, en=1 → count=1, ovf=1 for one cycle, then 0.
- Wrap down: MOD=10, count=1, step=3, mode=0, sat=0 → count=8, unf=1 for one cycle.
- Saturate: MOD=10, sat=1, up from count=8 with step=3 → count=9, ovf=1. Hold en for 2 more cycles → count stays 9, ovf=1 each cycle, at_max=1. Switch to down, step=9 → count=0, at_min=1, no unf.
- Load clamp and hold: load_val=200 with MOD=10 → count=9, no flags. en=0 for 5 cycles → count stays 9. step=0 with en=1 → count stays 9, no flags.
- Sticky (UDC_STICKY_FLAGS_EN): trigger ovf → ovf_sticky=1 and persists for 10 cycles. flag_clr=1 together with a new ovf event → ovf_sticky stays 1. flag_clr alone → ovf_sticky=0 the next cycle.
